// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the simple CPU: opcodes, ALU functions, PC actions,
// controller states and instruction field positions.
package cpu_ctrl_pkg;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 10;
    localparam int RS_HI  = 9;
    localparam int RS_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_MVI  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_LDA  = 4'hA;
    localparam logic [3:0] OP_STA  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JR   = 4'hD;
    localparam logic [3:0] OP_ADDI = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_OR     = 3'b011;
    localparam logic [2:0] ALU_XOR    = 3'b100;
    localparam logic [2:0] ALU_PASS_B = 3'b101;
    localparam logic [2:0] ALU_SHL    = 3'b110;
    localparam logic [2:0] ALU_SHR    = 3'b111;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b10;
    localparam logic [1:0] PC_REL  = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_WAIT   = 4'd4,
        ST_MEM    = 4'd5,
        ST_WB     = 4'd6,
        ST_PCUP   = 4'd7,
        ST_HALT   = 4'd8,
        ST_ERR    = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_MEM  = 2'd1,
        CLS_PC   = 2'd2,
        CLS_HALT = 2'd3
    } op_class_t;

    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/cpu_ctrl_unit_instr_decoder.sv
// Combinational opcode decode: instruction class plus the ALU, memory and
// PC controls the sequencer latches for the rest of the instruction.
module instr_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [1:0] op_class,
    output logic [2:0] alu_func,
    output logic       alu_in_sel,
    output logic       is_load,
    output logic       is_store,
    output logic [1:0] pc_mode
);

    always_comb begin
        op_class   = CLS_ALU;
        alu_func   = ALU_ADD;
        alu_in_sel = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        pc_mode    = PC_INC;
        case (opcode)
            OP_NOP:  op_class = CLS_PC;
            OP_MOV:  alu_func = ALU_PASS_B;
            OP_MVI: begin
                alu_func   = ALU_PASS_B;
                alu_in_sel = 1'b1;
            end
            OP_ADD:  alu_func = ALU_ADD;
            OP_SUB:  alu_func = ALU_SUB;
            OP_AND:  alu_func = ALU_AND;
            OP_OR:   alu_func = ALU_OR;
            OP_XOR:  alu_func = ALU_XOR;
            OP_SHL:  alu_func = ALU_SHL;
            OP_SHR:  alu_func = ALU_SHR;
            OP_LDA: begin
                op_class = CLS_MEM;
                is_load  = 1'b1;
            end
            OP_STA: begin
                op_class = CLS_MEM;
                is_store = 1'b1;
            end
            OP_JMP: begin
                op_class = CLS_PC;
                pc_mode  = PC_LOAD;
            end
            OP_JR: begin
                op_class = CLS_PC;
                pc_mode  = PC_REL;
            end
            OP_ADDI: begin
                alu_func   = ALU_ADD;
                alu_in_sel = 1'b1;
            end
            OP_HLT: begin
                op_class = CLS_HALT;
                pc_mode  = PC_HOLD;
            end
            default: op_class = CLS_PC;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_unit.sv
// Multi-cycle control FSM for the simple CPU data path: fetch, decode,
// execute/memory, write-back and PC update, with an ALU completion timeout.
module cpu_ctrl_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int DONE_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] instr,
    input  logic        alu_done,
    output logic        en_pc,
    output logic [1:0]  pc_ctrl,
    output logic [7:0]  offset,
    output logic        en_group,
    output logic [3:0]  reg_en,
    output logic [1:0]  rd,
    output logic [1:0]  rs,
    output logic        alu_in_sel,
    output logic [2:0]  alu_func,
    output logic        mem_to_reg,
    output logic        ram_we,
    output logic        busy,
    output logic        halted,
    output logic        error
);

    localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      instr_q, instr_d;
    logic [1:0]       cls_q, cls_d;
    logic [2:0]       alu_func_q, alu_func_d;
    logic             alu_in_sel_q, alu_in_sel_d;
    logic             is_load_q, is_load_d;
    logic             is_store_q, is_store_d;
    logic [1:0]       pc_mode_q, pc_mode_d;

    logic [1:0] dec_class;
    logic [2:0] dec_func;
    logic       dec_in_sel;
    logic       dec_load;
    logic       dec_store;
    logic [1:0] dec_pc_mode;

    // Decoding the raw fetch data lets every control field be a flop by DECODE.
    instr_decoder u_dec (
        .opcode     (instr[OPC_HI:OPC_LO]),
        .op_class   (dec_class),
        .alu_func   (dec_func),
        .alu_in_sel (dec_in_sel),
        .is_load    (dec_load),
        .is_store   (dec_store),
        .pc_mode    (dec_pc_mode)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            instr_q      <= '0;
            cls_q        <= '0;
            alu_func_q   <= '0;
            alu_in_sel_q <= 1'b0;
            is_load_q    <= 1'b0;
            is_store_q   <= 1'b0;
            pc_mode_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            instr_q      <= instr_d;
            cls_q        <= cls_d;
            alu_func_q   <= alu_func_d;
            alu_in_sel_q <= alu_in_sel_d;
            is_load_q    <= is_load_d;
            is_store_q   <= is_store_d;
            pc_mode_q    <= pc_mode_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        instr_d      = instr_q;
        cls_d        = cls_q;
        alu_func_d   = alu_func_q;
        alu_in_sel_d = alu_in_sel_q;
        is_load_d    = is_load_q;
        is_store_d   = is_store_q;
        pc_mode_d    = pc_mode_q;
        en_pc        = 1'b0;
        pc_ctrl      = PC_HOLD;
        en_group     = 1'b0;
        reg_en       = 4'b0000;
        ram_we       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                instr_d      = instr[11:0];
                cls_d        = dec_class;
                alu_func_d   = dec_func;
                alu_in_sel_d = dec_in_sel;
                is_load_d    = dec_load;
                is_store_d   = dec_store;
                pc_mode_d    = dec_pc_mode;
                state_d      = ST_DECODE;
            end
            ST_DECODE: begin
                case (cls_q)
                    CLS_ALU:  state_d = ST_EXEC;
                    CLS_MEM:  state_d = ST_MEM;
                    CLS_PC:   state_d = ST_PCUP;
                    default:  state_d = ST_HALT;
                endcase
            end
            ST_EXEC: begin
                en_group = 1'b1;
                cnt_d    = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completion in the final allowed cycle still counts.
                if (alu_done)               state_d = ST_WB;
                else if (cnt_q == CNT_LAST) state_d = ST_ERR;
            end
            ST_MEM: begin
                if (is_store_q) begin
                    ram_we   = 1'b1;
                    en_group = 1'b1;
                    state_d  = ST_PCUP;
                end else begin
                    state_d  = ST_WB;
                end
            end
            ST_WB: begin
                en_group = 1'b1;
                reg_en   = reg_onehot(instr_q[RD_HI:RD_LO]);
                state_d  = ST_PCUP;
            end
            ST_PCUP: begin
                en_pc   = 1'b1;
                pc_ctrl = pc_mode_q;
                state_d = start ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    assign offset     = instr_q[IMM_HI:IMM_LO];
    assign rd         = instr_q[RD_HI:RD_LO];
    assign rs         = instr_q[RS_HI:RS_LO];
    assign alu_func   = alu_func_q;
    assign alu_in_sel = alu_in_sel_q;
    assign mem_to_reg = is_load_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_ERR);
    assign halted     = (state_q == ST_HALT);
    assign error      = (state_q == ST_ERR);

endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// Directed bench for cpu_ctrl_unit: runs single instructions from FETCH and
// records when each control strobe appears, against hand-derived expectations.
module tb_cpu_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        alu_done = 1'b0;
    logic        en_pc;
    logic [1:0]  pc_ctrl;
    logic [7:0]  offset;
    logic        en_group;
    logic [3:0]  reg_en;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic        alu_in_sel;
    logic [2:0]  alu_func;
    logic        mem_to_reg;
    logic        ram_we;
    logic        busy;
    logic        halted;
    logic        error;

    cpu_ctrl_unit #(.DONE_TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .instr      (instr),
        .alu_done   (alu_done),
        .en_pc      (en_pc),
        .pc_ctrl    (pc_ctrl),
        .offset     (offset),
        .en_group   (en_group),
        .reg_en     (reg_en),
        .rd         (rd),
        .rs         (rs),
        .alu_in_sel (alu_in_sel),
        .alu_func   (alu_func),
        .mem_to_reg (mem_to_reg),
        .ram_we     (ram_we),
        .busy       (busy),
        .halted     (halted),
        .error      (error)
    );

    always #5 clk = ~clk;

    logic [31:0] outs_all;
    assign outs_all = {3'b000, en_pc, pc_ctrl, offset, en_group, reg_en, rd, rs,
                       alu_in_sel, alu_func, mem_to_reg, ram_we, busy, halted, error};

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-instruction observations, cycle 0 = FETCH
    int         pcup_at, exec_at, err_at, halt_at;
    int         grp_cnt, we_cnt, regen_nz, busy_low, stray_pc;
    logic [3:0] wb_reg_en;
    logic [2:0] wb_func;
    logic       wb_sel, wb_m2r;
    logic [1:0] wb_rd, wb_rs, we_rs, pcup_ctrl;
    logic [7:0] we_off, pcup_off;

    // Called while the DUT sits in FETCH; done_after < 0 withholds alu_done.
    task automatic run_instr(input logic [15:0] w, input int done_after);
        int n;
        instr = w;
        pcup_at = -1; exec_at = -1; err_at = -1; halt_at = -1;
        grp_cnt = 0; we_cnt = 0; regen_nz = 0; busy_low = 0; stray_pc = 0;
        wb_reg_en = '0; wb_func = '0; wb_sel = 1'b0; wb_m2r = 1'b0;
        wb_rd = '0; wb_rs = '0; we_rs = '0; pcup_ctrl = '0; we_off = '0; pcup_off = '0;
        n = 0;
        while (pcup_at < 0 && n < 20) begin
            alu_done = (done_after >= 0 && exec_at >= 0 && n == exec_at + done_after);
            if (en_group && reg_en == 4'b0000 && !ram_we && exec_at < 0) exec_at = n;
            if (en_group) grp_cnt++;
            if (ram_we) begin
                we_cnt++;
                we_off = offset;
                we_rs  = rs;
            end
            if (reg_en != 4'b0000) begin
                regen_nz++;
                wb_reg_en = reg_en; wb_func = alu_func; wb_sel = alu_in_sel;
                wb_rd = rd; wb_rs = rs; wb_m2r = mem_to_reg;
            end
            if (!en_pc && pc_ctrl != 2'b00) stray_pc++;
            if (error && err_at < 0) err_at = n;
            if (halted && halt_at < 0) halt_at = n;
            if (!busy && !error && !halted) busy_low++;
            if (en_pc) begin
                pcup_at   = n;
                pcup_ctrl = pc_ctrl;
                pcup_off  = offset;
            end
            @(posedge clk);
            #1;
            n++;
        end
        alu_done = 1'b0;
        $display("instr %h: exec@%0d pcup@%0d err@%0d halt@%0d grp=%0d we=%0d",
                 w, exec_at, pcup_at, err_at, halt_at, grp_cnt, we_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_outs", outs_all, 32'h0);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        chk("fetch_busy", {31'b0, busy}, 32'd1);

        // MVI r3,5
        run_instr(16'h2C05, 3);
        chk("mvi_exec_at",  exec_at, 2);
        chk("mvi_cycles",   pcup_at + 1, 8);
        chk("mvi_reg_en",   wb_reg_en, 4'b1000);
        chk("mvi_func",     wb_func, 3'b101);
        chk("mvi_sel",      wb_sel, 1'b1);
        chk("mvi_pc_ctrl",  pcup_ctrl, 2'b01);
        chk("mvi_grp_cnt",  grp_cnt, 2);
        chk("mvi_busy_low", busy_low, 0);
        chk("mvi_stray_pc", stray_pc, 0);

        // ADD r1,r0
        run_instr(16'h3400, 3);
        chk("add_cycles",  pcup_at + 1, 8);
        chk("add_func",    wb_func, 3'b000);
        chk("add_sel",     wb_sel, 1'b0);
        chk("add_rd",      wb_rd, 2'd1);
        chk("add_rs",      wb_rs, 2'd0);
        chk("add_reg_en",  wb_reg_en, 4'b0010);

        // STA [0x0A],r1
        run_instr(16'hB10A, -1);
        chk("sta_cycles",  pcup_at + 1, 4);
        chk("sta_we_cnt",  we_cnt, 1);
        chk("sta_we_off",  we_off, 8'h0A);
        chk("sta_we_rs",   we_rs, 2'd1);
        chk("sta_regen",   regen_nz, 0);
        chk("sta_pc_ctrl", pcup_ctrl, 2'b01);

        // LDA r2,[0x0C]
        run_instr(16'hA80C, -1);
        chk("lda_cycles",  pcup_at + 1, 5);
        chk("lda_reg_en",  wb_reg_en, 4'b0100);
        chk("lda_m2r",     wb_m2r, 1'b1);
        chk("lda_grp_cnt", grp_cnt, 1);
        chk("lda_we_cnt",  we_cnt, 0);

        // JR -2
        run_instr(16'hD0FE, -1);
        chk("jr_cycles",   pcup_at + 1, 3);
        chk("jr_pc_ctrl",  pcup_ctrl, 2'b11);
        chk("jr_offset",   pcup_off, 8'hFE);
        chk("jr_grp_cnt",  grp_cnt, 0);

        // JMP 0x12
        run_instr(16'hC012, -1);
        chk("jmp_cycles",  pcup_at + 1, 3);
        chk("jmp_pc_ctrl", pcup_ctrl, 2'b10);
        chk("jmp_offset",  pcup_off, 8'h12);

        // alu_done in the last allowed WAIT cycle still wins over the timeout
        run_instr(16'h6D00, 8);
        chk("edge_cycles", pcup_at + 1, 13);
        chk("edge_err",    err_at, -1);
        chk("edge_func",   wb_func, 3'b011);
        chk("edge_reg_en", wb_reg_en, 4'b1000);

        // NOP with start dropped mid-instruction: completes, then idles
        start = 1'b0;
        run_instr(16'h0000, -1);
        chk("nop_cycles",  pcup_at + 1, 3);
        chk("nop_pc_ctrl", pcup_ctrl, 2'b01);
        chk("idle_busy",   {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("idle_stays",  {30'b0, busy, en_pc}, 32'd0);
        start = 1'b1;
        @(posedge clk); #1;

        // HLT: sticky, no further PC strobes while start stays high
        run_instr(16'hF000, -1);
        chk("hlt_at",      halt_at, 2);
        chk("hlt_no_pc",   pcup_at, -1);
        chk("hlt_busy",    {30'b0, busy, halted}, 32'd1);

        // Reset out of HALT, then ALU op that never completes
        rst = 1'b0;
        #1;
        chk("rst_from_halt", outs_all, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_instr(16'h3400, -1);
        chk("to_err_at",   err_at, 11);
        chk("to_no_pc",    pcup_at, -1);
        chk("to_regen",    regen_nz, 0);
        alu_done = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        alu_done = 1'b0;
        chk("err_sticky",  {28'b0, reg_en == 4'b0000, en_pc, busy, error}, 32'b1001);

        // Asynchronous reset mid-cycle clears everything without a clock edge
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst",   outs_all, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_unit.md
# cpu_ctrl_unit

Multi-cycle control FSM that drives the simple CPU data path: fetches a 16-bit instruction addressed by the data path's `pc_out`, decodes it, and sequences register read, ALU execution, RAM access, write-back and PC update. It is the initiator for every data-path control strobe. It consumes only the ALU completion strobe (`alu_done`) and the fetched instruction word.

## Interface
Parameters:
- `DONE_TIMEOUT`, default 8: maximum cycles spent in WAIT for `alu_done` before the error state is entered.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; leaves IDLE when high.
- `instr`  in  16  instruction-memory read data for address `pc_out`; valid one cycle after the PC changes.
- `alu_done`  in  1  data-path `en_out`; single-cycle pulse when the ALU result is valid.
- `en_pc`  out  1  PC update strobe.
- `pc_ctrl`  out  2  PC action: 00 hold, 01 +1, 10 load `offset`, 11 add sign-extended `offset`.
- `offset`  out  8  `instr[7:0]`, held for the whole instruction.
- `en_group`  out  1  register-group enable (data-path `en_in`).
- `reg_en`  out  4  one-hot write select; non-zero only in WB.
- `rd`, `rs`  out  2 each  register indices, `instr[11:10]` and `instr[9:8]`.
- `alu_in_sel`  out  1  1 selects `offset` as ALU operand B.
- `alu_func`  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS_B, 110 SHL, 111 SHR.
- `mem_to_reg`  out  1  write-back source is RAM.
- `ram_we`  out  1  RAM write strobe, one cycle.
- `busy`, `halted`, `error`  out  1 each  status.

## Operation
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm/addr.
- Opcodes:
  - 0 NOP
  - 1 MOV rd,rs: PASS_B, sel=0
  - 2 MVI rd,imm: PASS_B, sel=1
  - 3–9 ADD/SUB/AND/OR/XOR/SHL/SHR rd,rs: ALU ops
  - A LDA rd,[imm]
  - B STA [imm],rs
  - C JMP imm: absolute
  - D JR imm: relative
  - E ADDI rd,imm
  - F HLT
- States:
  - IDLE → FETCH on `start`.
  - FETCH (1 cycle, memory latency) → DECODE: latch `instr`.
  - DECODE → EXEC for ALU ops; → MEM for LDA/STA; → PCUP for NOP/JMP/JR; → HALT for HLT.
  - EXEC: pulse `en_group` one cycle; → WAIT.
  - WAIT: hold until `alu_done` → WB; if the counter reaches `DONE_TIMEOUT` → ERR.
  - MEM: LDA → WB with `mem_to_reg`=1 (RAM read is combinational on `offset[3:0]`); STA pulses `ram_we` with `en_group`=1 → PCUP.
  - WB: `en_group`=1, `reg_en`=1<<rd for one cycle → PCUP.
  - PCUP: `en_pc`=1; `pc_ctrl`=01, or 10 for JMP, or 11 for JR → FETCH.
  - HALT and ERR are sticky until reset.
- `alu_func`/`alu_in_sel`/`rd`/`rs`/`offset`/`mem_to_reg` are registered and held from DECODE through PCUP.
- `alu_done` outside WAIT is ignored.
- `start` deassertion mid-instruction is ignored; the instruction completes, then the FSM returns to IDLE instead of FETCH.

## Timing
- Reset: every output 0, state IDLE, timeout counter 0, latched instruction 0.
- Asynchronous assert; all registers update on the rising `clk` edge.
- Cycle counts from start of FETCH to start of the next FETCH:
  - ALU op: FETCH, DECODE, EXEC, WAIT ×3 (data path has 3-stage latency), WB, PCUP = 8 cycles.
  - LDA: 5 cycles. STA: 4 cycles. NOP/JMP/JR: 3 cycles.
- Timeout counter clears on entry to WAIT. `alu_done` arriving in the same cycle the counter hits the limit wins: go to WB.
- `busy` = state not in {IDLE, HALT, ERR}. `halted`/`error` are asserted from the cycle after entry.

## Structure
- `cpu_ctrl_pkg`: opcode constants, ALU function codes, `pc_ctrl` codes, state enumeration, field bit positions. Shared with the data path and testbench.
- Sub-module `instr_decoder`: combinational; maps opcode to class (ALU/MEM/PC/HALT), `alu_func`, `alu_in_sel`, `is_load`, `is_store`, `pc_mode`.

## Test plan
- Reset, then `start`=1, `instr`=0x2C05 (MVI r3,5), `alu_done` returned 3 cycles after EXEC -> `en_group` pulses in EXEC; WB shows `reg_en`=1000 and `alu_func`=101, `alu_in_sel`=1; PCUP shows `pc_ctrl`=01; 8 cycles total.
- `instr`=0x3400 (ADD r1,r0) -> `alu_func`=000, `alu_in_sel`=0, `rd`=1, `rs`=0; `reg_en`=0010 in WB.
- `instr`=0xB10A (STA [0x0A],r1) -> `ram_we`=1 for exactly one cycle with `offset`=0x0A and `rs`=1; `reg_en` never non-zero; 4 cycles.
- `instr`=0xD0FE (JR -2) -> PCUP shows `pc_ctrl`=11 and `offset`=0xFE; no `en_group`.
- ALU op with `alu_done` withheld -> `error`=1 after `DONE_TIMEOUT` WAIT cycles; later `alu_done` pulses ignored; asserting `rst`=0 returns all outputs to 0.
- `instr`=0xF000 (HLT) -> `halted`=1, `busy`=0, no further `en_pc` with `start` still high.
